// File: rtl/control_merge_dataless_pkg.sv
// Shared definitions for the dataless control merge: index-width helpers
// used by the elaboration-time parameter check, and the sent-bit state type
// of the eager fork register blocks.
package control_merge_dataless_pkg;

  // Ceiling log2, with a floor of 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // True when an index of 'width' bits can address 'size' inputs.
  // A width of at least one bit is always required, even for a single input.
  function automatic bit index_width_ok(input int size, input int width);
    return (size >= 1) && (width >= 1) && (clog2(size) <= width);
  endfunction

  // Per-output state of the eager fork: still owed the current token, or
  // already delivered it and waiting for the other output to catch up.
  typedef enum logic {
    FORK_PENDING = 1'b0,
    FORK_SENT    = 1'b1
  } sent_state_t;

endpackage

// File: rtl/control_merge_dataless_eager_fork_register_block.sv
// One leg of an eager fork: remembers whether its consumer already took the
// current token so it is not offered twice while the other leg is stalled.
module control_merge_dataless_eager_fork_register_block
  import control_merge_dataless_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ins_valid,
  input  logic fork_ready,
  output logic outs_valid,
  input  logic outs_ready,
  output logic done
);

  sent_state_t state;
  sent_state_t state_next;

  // Sent-bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FORK_PENDING;
    end else begin
      state <= state_next;
    end
  end

  // Offer the token until accepted; clear once every leg is done with it.
  always_comb begin
    outs_valid = ins_valid & (state == FORK_PENDING);
    done       = outs_ready | (state == FORK_SENT);
    state_next = state;
    if (fork_ready) begin
      state_next = FORK_PENDING;
    end else if (outs_valid && outs_ready) begin
      state_next = FORK_SENT;
    end
  end

endmodule

// File: rtl/control_merge_dataless_tehb.sv
// One-slot transparent elastic buffer. Data passes straight through while
// empty; when the consumer stalls, the current word is captured and the
// producer is held off until the consumer accepts it.
module control_merge_dataless_tehb #(
  parameter int DATA_TYPE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
);

  logic                 full;
  logic [DATA_TYPE-1:0] stored;

  // Capture the word on a stall; the slot keeps its contents until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 1'b0;
      stored <= '0;
    end else begin
      full <= outs_valid & ~outs_ready;
      if (!full) begin
        stored <= ins;
      end
    end
  end

  // Present the buffered word while full, otherwise the live input.
  always_comb begin
    outs_valid = ins_valid | full;
    outs       = full ? stored : ins;
    ins_ready  = ~full;
  end

endmodule

// File: rtl/control_merge_dataless.sv
// Dataless control merge: a fixed-priority merge of SIZE token inputs into a
// one-slot buffer holding the winner's index, followed by an eager fork that
// delivers the token on the dataless output and the index on its own channel.
module control_merge_dataless
  import control_merge_dataless_pkg::*;
#(
  parameter int SIZE       = 2,
  parameter int INDEX_TYPE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SIZE-1:0]       ins_valid,
  output logic [SIZE-1:0]       ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [INDEX_TYPE-1:0] index,
  output logic                  index_valid,
  input  logic                  index_ready
);

  if (!index_width_ok(SIZE, INDEX_TYPE)) begin : g_bad_index_width
    $error("control_merge_dataless: INDEX_TYPE=%0d cannot address SIZE=%0d inputs",
           INDEX_TYPE, SIZE);
  end

  logic [INDEX_TYPE-1:0] sel;
  logic                  any_valid;
  logic                  merge_valid;
  logic                  tehb_in_ready;
  logic [INDEX_TYPE-1:0] tehb_index;
  logic                  tehb_valid;
  logic                  fork_valid;
  logic                  fork_ready;
  logic                  done_outs;
  logic                  done_index;

  // Fixed priority: scanning from the top down leaves the lowest valid input selected.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (ins_valid[i]) begin
        sel       = INDEX_TYPE'(i);
        any_valid = 1'b1;
      end
    end
  end

  // Tokens offered while reset is asserted are neither granted nor forwarded.
  always_comb begin
    merge_valid = any_valid & ~rst;
    fork_valid  = tehb_valid & ~rst;
    fork_ready  = done_outs & done_index;
  end

  // Grant only the selected input, and only while the buffer slot is free.
  always_comb begin
    ins_ready = '0;
    for (int i = 0; i < SIZE; i++) begin
      ins_ready[i] = tehb_in_ready & merge_valid & (sel == INDEX_TYPE'(i));
    end
  end

  control_merge_dataless_tehb #(
    .DATA_TYPE(INDEX_TYPE)
  ) u_tehb (
    .clk       (clk),
    .rst       (rst),
    .ins       (sel),
    .ins_valid (merge_valid),
    .ins_ready (tehb_in_ready),
    .outs      (tehb_index),
    .outs_valid(tehb_valid),
    .outs_ready(fork_ready)
  );

  control_merge_dataless_eager_fork_register_block u_fork_outs (
    .clk       (clk),
    .rst       (rst),
    .ins_valid (fork_valid),
    .fork_ready(fork_ready),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready),
    .done      (done_outs)
  );

  control_merge_dataless_eager_fork_register_block u_fork_index (
    .clk       (clk),
    .rst       (rst),
    .ins_valid (fork_valid),
    .fork_ready(fork_ready),
    .outs_valid(index_valid),
    .outs_ready(index_ready),
    .done      (done_index)
  );

  // The index reads zero during reset so a discarded token's position never shows.
  always_comb begin
    index = rst ? '0 : tehb_index;
  end

endmodule

// File: tb/tb_control_merge_dataless.sv
// Scoreboard bench for control_merge_dataless with four inputs. Granted inputs
// push their expected index; a monitor pops on each output transfer.
module tb_control_merge_dataless;

  localparam int SIZE = 4;
  localparam int IW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] ins_valid;
  logic [SIZE-1:0] ins_ready;
  logic            outs_valid;
  logic            outs_ready;
  logic [IW-1:0]   index;
  logic            index_valid;
  logic            index_ready;

  int errors = 0;
  int checks = 0;
  int exp_idx_q[$];
  int exp_out_q[$];

  control_merge_dataless #(
    .SIZE      (SIZE),
    .INDEX_TYPE(IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .index      (index),
    .index_valid(index_valid),
    .index_ready(index_ready)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic int lowest(input logic [SIZE-1:0] v);
    for (int i = 0; i < SIZE; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [SIZE-1:0] v, input logic o_rdy, input logic i_rdy);
    @(posedge clk);
    #1;
    ins_valid   = v;
    outs_ready  = o_rdy;
    index_ready = i_rdy;
    @(negedge clk);
  endtask

  task automatic expectOutputs(input string tag, input logic ov, input logic iv,
                               input logic [IW-1:0] idx, input logic [SIZE-1:0] rdy);
    checkOutput({tag, "_outs_valid"}, outs_valid, ov);
    checkOutput({tag, "_index_valid"}, index_valid, iv);
    checkOutput({tag, "_index"}, index, idx);
    checkOutput({tag, "_ins_ready"}, ins_ready, rdy);
  endtask

  // Monitor: pushes expectations on input grants, pops on output transfers.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_idx_q.delete();
        exp_out_q.delete();
      end else begin
        if ((ins_valid & ins_ready) != '0) begin
          checkOutput("grant_onehot", ins_ready, 32'd1 << lowest(ins_valid));
          exp_idx_q.push_back(lowest(ins_valid));
          exp_out_q.push_back(lowest(ins_valid));
        end
        if (index_valid && index_ready) begin
          if (exp_idx_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL index_unexpected: actual=index transfer %0d required=no transfer at %0t", index, $time);
          end else begin
            checkOutput("index_sb", index, exp_idx_q.pop_front());
          end
        end
        if (outs_valid && outs_ready) begin
          checks++;
          if (exp_out_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL outs_unexpected: actual=outs transfer required=no transfer at %0t", $time);
          end else begin
            void'(exp_out_q.pop_front());
          end
        end
      end
    end
  end

  // Time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence, random streaming phase, then the summary.
  initial begin
    rst         = 1'b1;
    ins_valid   = 4'b0011;
    outs_ready  = 1'b1;
    index_ready = 1'b1;

    // Reset held two cycles with inputs valid.
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    expectOutputs("reset", 1'b0, 1'b0, 2'd0, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expectOutputs("release", 1'b1, 1'b1, 2'd0, 4'b0001);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    expectOutputs("idle", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Priority.
    applyStimulus(4'b1100, 1'b1, 1'b1);
    expectOutputs("prio2", 1'b1, 1'b1, 2'd2, 4'b0100);
    applyStimulus(4'b1000, 1'b1, 1'b1);
    expectOutputs("prio3", 1'b1, 1'b1, 2'd3, 4'b1000);
    applyStimulus(4'b0000, 1'b1, 1'b1);

    // Full stall: index must hold even though lower inputs become valid.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    expectOutputs("stall_in", 1'b1, 1'b1, 2'd1, 4'b0010);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b0101, 1'b0, 1'b0);
      expectOutputs("stall_hold", 1'b1, 1'b1, 2'd1, 4'b0000);
    end
    applyStimulus(4'b0000, 1'b1, 1'b1);
    expectOutputs("stall_release", 1'b1, 1'b1, 2'd1, 4'b0000);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    expectOutputs("stall_after", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Split acceptance: index first, outs two cycles later.
    applyStimulus(4'b0001, 1'b0, 1'b1);
    expectOutputs("split_n", 1'b1, 1'b1, 2'd0, 4'b0001);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    expectOutputs("split_n1", 1'b1, 1'b0, 2'd0, 4'b0000);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    expectOutputs("split_n2", 1'b1, 1'b0, 2'd0, 4'b0000);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    expectOutputs("split_done", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Split acceptance: outs first, index two cycles later.
    applyStimulus(4'b0100, 1'b1, 1'b0);
    expectOutputs("splitr_n", 1'b1, 1'b1, 2'd2, 4'b0100);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    expectOutputs("splitr_n1", 1'b0, 1'b1, 2'd2, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    expectOutputs("splitr_n2", 1'b0, 1'b1, 2'd2, 4'b0000);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    expectOutputs("splitr_done", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Streaming over the lower three inputs with mostly-ready consumers.
    for (int c = 0; c < 1000; c++) begin
      applyStimulus(4'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 9) < 7));
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0000, 1'b1, 1'b1);
    end
    #1;
    checkOutput("stream_drain_index", exp_idx_q.size(), 0);
    checkOutput("stream_drain_outs", exp_out_q.size(), 0);

    // Reset while a token is buffered: it must be discarded.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    expectOutputs("midrst_full", 1'b1, 1'b1, 2'd1, 4'b0000);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    outs_ready  = 1'b1;
    index_ready = 1'b1;
    @(negedge clk);
    expectOutputs("midrst_during", 1'b0, 1'b0, 2'd0, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expectOutputs("midrst_after", 1'b0, 1'b0, 2'd0, 4'b0000);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    expectOutputs("midrst_noreplay", 1'b0, 1'b0, 2'd0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_merge_dataless.md
# control_merge_dataless

Converging counterpart of the dataless lazy fork: arbitrates among SIZE dataless input channels and forwards one token per cycle to a dataless output channel. The winning input's position goes out on a separate index channel. Internally it is a priority merge, then a one-slot transparent buffer (TEHB) holding the index, then a two-way eager fork. Used at control-flow join points (loop headers, if/else reconvergence), where the index channel drives downstream muxes.

## Interface
- SIZE, 2: number of input channels, ≥1
- INDEX_TYPE, 1: index width; must satisfy 2^INDEX_TYPE ≥ SIZE, with a minimum of 1 when SIZE=1
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- ins_valid  in  SIZE  per-input valid
- ins_ready  out  SIZE  per-input ready
- outs_valid  out  1  dataless output valid
- outs_ready  in  1  dataless output ready
- index  out  INDEX_TYPE  position of the input that supplied the current token
- index_valid  out  1  index channel valid
- index_ready  in  1  index channel ready

## Operation
- Arbitration (combinational): sel is the lowest i with ins_valid[i]=1. any_valid is the OR of ins_valid.
- TEHB state: full (1 bit) and stored_index (INDEX_TYPE bits).
  - tehb_valid = any_valid | full
  - tehb_index = full ? stored_index : sel
  - tehb_in_ready = ~full
- Input handshake: ins_ready[i] = tehb_in_ready & any_valid & (i == sel). All other inputs see ready=0.
- TEHB update:
  - full <= tehb_valid & ~fork_ready
  - when ~full, stored_index <= sel
- Eager fork state: sent_o and sent_i, one bit per output.
  - outs_valid = tehb_valid & ~sent_o
  - index_valid = tehb_valid & ~sent_i
  - index = tehb_index
  - fork_ready = (outs_ready | sent_o) & (index_ready | sent_i)
  - sent_x <= fork_ready ? 0 : sent_x | (valid_x & ready_x)
- A token is consumed from the buffer only when both outputs have accepted it, in the same cycle or in different cycles.
- Reset: full=0, stored_index=0, sent_o=0, sent_i=0. With all ins_valid=0, all outputs read 0: outs_valid, index_valid, ins_ready, and index=0.

## Timing
- Latency 0 when the buffer is empty: ins_valid[i] reaches outs_valid and index_valid in the same cycle.
- ins_ready is gated by the registered full bit, so there is no combinational path from outs_ready or index_ready to ins_ready.
- Throughput: 1 token/cycle while both consumers stay ready.
- Stall: if either consumer is not ready, full sets at the next edge and ins_ready drops to 0 at every input. stored_index is held until fork_ready=1, then full clears at the following edge.
- Split acceptance: one output accepts in cycle n and the other in cycle n+k. The first output's valid is 0 during cycles n+1..n+k. The token retires at the end of cycle n+k.
- Simultaneous valids: the lowest index wins. The others keep their valid high and are served in later cycles in priority order. There is no fairness guarantee; starvation of high indices under continuous low-index traffic is accepted.
- Reset mid-operation: reset overrides all state on the same edge, so a buffered token and any partial sends are discarded.
- Index must stay stable while index_valid=1 and not yet accepted. This is guaranteed because full is set during the stall.

## Structure
- Shared package: clog2 function and an index-width check used by the elaboration-time assertion (2^INDEX_TYPE ≥ SIZE).
- Sub-modules:
  - tehb, reusable one-slot transparent buffer, parameter DATA_TYPE, instantiated here with DATA_TYPE=INDEX_TYPE.
  - eager_fork_register_block, one sent bit with its valid/ready logic, instantiated twice.
- Priority arbitration and ins_ready decode live in the top module.

## Test plan
- Reset: hold rst=1 for 2 cycles with ins_valid=2'b11. Expect all outputs at 0 and ins_ready=0 during reset. In the first cycle after release, expect outs_valid=1, index=0, ins_ready=2'b01.
- Priority: SIZE=4, ins_valid=4'b1100, both consumers ready. Expect index=2, ins_ready=4'b0100. The next cycle with ins_valid=4'b1000 gives index=3.
- Full stall: outs_ready=0, index_ready=0, ins_valid=2'b10 for one cycle then 0. Expect full=1, ins_ready=0, index held at 1 for 5 cycles. When both readies go 1, expect one transfer and outs_valid=0 on the next cycle.
- Split acceptance: index_ready=1, outs_ready=0 in cycle n, then outs_ready=1 in cycle n+2. Expect index_valid=0 in cycles n+1 and n+2, exactly one index transfer, one outs transfer at n+2, and the token retired at the end of n+2.
- Streaming: SIZE=3, random ins_valid and 70%-ready consumers for 1000 cycles. Expect the count of index transfers equal to accepted inputs, and each index equal to the lowest valid input at acceptance.
- Reset mid-stall: buffer full with index=1, assert rst for 1 cycle. Expect outs_valid=0 and index_valid=0 after reset, and the buffered token not replayed.
